// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the serial adder.
// The controller drives through master; the adder sits on slave.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: consumes STEP bits per clock through a one-bit carry
// register, taking WIDTH/STEP clocks per addition behind a start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_cnt;

  logic [STEP:0]    w_slice;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_slice = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]}
                 + {{STEP{1'b0}}, r_carry};
  assign w_last  = (r_cnt == CW'(N - 1));

  // Partial sums enter at the MSB end so the result is aligned after N shifts.
  generate
    if (STEP == WIDTH) begin : g_full
      assign w_acc_next = w_slice[STEP-1:0];
    end else begin : g_shift
      assign w_acc_next = {w_slice[STEP-1:0], r_acc[WIDTH-1:STEP]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_a     <= r_a >> STEP;
          r_b     <= r_b >> STEP;
          r_carry <= w_slice[STEP];
          r_cnt   <= r_cnt + CW'(1);
          // Overflow uses the original operand MSBs; the shifted copies are gone.
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_slice[STEP];
            r_ovf   <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four (WIDTH, STEP) instances checked every cycle
// against a transaction-level arithmetic model, plus hand-computed vectors.
module tb_serial_adder;

  function automatic int cfgW(input int i);
    case (i)
      0:       return 8;
      1:       return 8;
      2:       return 16;
      default: return 16;
    endcase
  endfunction

  function automatic int cfgS(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int cfgN(input int i);
    return cfgW(i) / cfgS(i);
  endfunction

  logic        clk  = 1'b0;
  logic        rstN = 1'b1;
  logic [15:0] stA    [4];
  logic [15:0] stB    [4];
  logic        stCin  [4];
  logic        stStart[4];
  logic [15:0] obsSum [4];
  logic        obsBusy[4];
  logic        obsDone[4];
  logic        obsCout[4];
  logic        obsOvf [4];

  logic        mBusy[4];
  logic        mDone[4];
  logic        mCout[4];
  logic        mOvf [4];
  logic [15:0] mSum [4];
  int          mLeft[4];
  logic [15:0] pSum [4];
  logic        pCout[4];
  logic        pOvf [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int W = cfgW(gi);
    localparam int S = cfgS(gi);

    serial_adder_if #(.WIDTH(W)) bus ();

    assign bus.start = stStart[gi];
    assign bus.a     = stA[gi][W-1:0];
    assign bus.b     = stB[gi][W-1:0];
    assign bus.cin   = stCin[gi];

    serial_adder #(.WIDTH(W), .STEP(S)) dut (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (bus.slave)
    );

    assign obsSum[gi]  = 16'(bus.sum);
    assign obsBusy[gi] = bus.busy;
    assign obsDone[gi] = bus.done;
    assign obsCout[gi] = bus.cout;
    assign obsOvf[gi]  = bus.overflow;
  end

  // Reference: unsigned sum for sum/cout, signed range test for overflow.
  task automatic modelAccept(input int i);
    int     w;
    longint mask, half, av, bv, sa, sb, full, st;
    w    = cfgW(i);
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av   = longint'(stA[i]) & mask;
    bv   = longint'(stB[i]) & mask;
    full = av + bv + longint'(stCin[i]);
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    st   = sa + sb + longint'(stCin[i]);
    pSum[i]  = 16'(full & mask);
    pCout[i] = ((full >> w) != 0);
    pOvf[i]  = (st >= half) || (st < -half);
  endtask

  task automatic modelClear();
    for (int i = 0; i < 4; i++) begin
      mBusy[i] = 1'b0;
      mDone[i] = 1'b0;
      mCout[i] = 1'b0;
      mOvf[i]  = 1'b0;
      mSum[i]  = '0;
      mLeft[i] = 0;
    end
  endtask

  // Model: an accepted start schedules the result N edges later.
  initial begin
    modelClear();
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        modelClear();
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (mBusy[i]) begin
            mLeft[i] = mLeft[i] - 1;
            if (mLeft[i] == 0) begin
              mBusy[i] = 1'b0;
              mDone[i] = 1'b1;
              mSum[i]  = pSum[i];
              mCout[i] = pCout[i];
              mOvf[i]  = pOvf[i];
            end else begin
              mDone[i] = 1'b0;
            end
          end else begin
            mDone[i] = 1'b0;
            if (stStart[i]) begin
              modelAccept(i);
              mBusy[i] = 1'b1;
              mLeft[i] = cfgN(i);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [19:0] act, exp;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        act = {obsBusy[i], obsDone[i], obsCout[i], obsOvf[i], obsSum[i]};
        exp = {mBusy[i], mDone[i], mCout[i], mOvf[i], mSum[i]};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL cycle-cfg%0d t=%0t {busy,done,cout,ovf,sum}: got %h expected %h",
                   i, $time, act, exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [15:0] a, input logic [15:0] b,
                               input logic cin);
    @(negedge clk);
    stA[i]     = a;
    stB[i]     = b;
    stCin[i]   = cin;
    stStart[i] = 1'b1;
    @(negedge clk);
    stStart[i] = 1'b0;
  endtask

  task automatic waitDone(input int i, input string tag, output int busyCnt);
    int cyc;
    cyc     = 0;
    busyCnt = 0;
    while (obsDone[i] !== 1'b1 && cyc < 40) begin
      if (obsBusy[i] === 1'b1) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (obsDone[i] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s-timeout: done not seen within %0d cycles", tag, cyc);
    end
  endtask

  task automatic checkResult(input int i, input string tag, input int s, input int c,
                             input int o);
    checkOutput({tag, "-sum"}, int'(obsSum[i]), s);
    checkOutput({tag, "-cout"}, int'(obsCout[i]), c);
    checkOutput({tag, "-ovf"}, int'(obsOvf[i]), o);
  endtask

  initial begin
    int busyCnt, doneCnt;
    for (int i = 0; i < 4; i++) begin
      stA[i]     = '0;
      stB[i]     = '0;
      stCin[i]   = 1'b0;
      stStart[i] = 1'b0;
    end
    #1 rstN = 1'b0;
    @(negedge clk);
    checkResult(0, "reset0", 0, 0, 0);
    checkOutput("reset0-busy", int'(obsBusy[0]), 0);
    checkOutput("reset0-done", int'(obsDone[0]), 0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] directed vectors, WIDTH=8 STEP=1");
    applyStimulus(0, 16'h00FF, 16'h0001, 1'b0);
    waitDone(0, "ff+01", busyCnt);
    checkResult(0, "ff+01", 'h00, 1, 0);
    checkOutput("ff+01-busycycles", busyCnt, 8);

    applyStimulus(0, 16'h007F, 16'h0001, 1'b0);
    waitDone(0, "7f+01", busyCnt);
    checkResult(0, "7f+01", 'h80, 0, 1);

    applyStimulus(0, 16'h0080, 16'h0080, 1'b0);
    waitDone(0, "80+80", busyCnt);
    checkResult(0, "80+80", 'h00, 1, 1);

    // Start stays high for the first RUN cycles with other operands.
    @(negedge clk);
    stA[0] = 16'h0000; stB[0] = 16'h0000; stCin[0] = 1'b1; stStart[0] = 1'b1;
    @(negedge clk);
    stA[0] = 16'h0055; stB[0] = 16'h0022; stCin[0] = 1'b0;
    checkOutput("ignored-held-result", int'(obsSum[0]), 'h00);
    repeat (3) @(negedge clk);
    stStart[0] = 1'b0;
    waitDone(0, "00+00+1", busyCnt);
    checkResult(0, "00+00+1", 'h01, 0, 0);

    $display("[TB] directed vectors, WIDTH=16 STEP=4");
    @(negedge clk);
    stA[2] = 16'hFFFF; stB[2] = 16'hFFFF; stCin[2] = 1'b1; stStart[2] = 1'b1;
    @(negedge clk);
    stA[2] = 16'h1234; stB[2] = 16'h4321; stCin[2] = 1'b0;
    waitDone(2, "ffff+ffff+1", busyCnt);
    checkResult(2, "ffff+ffff+1", 'hFFFF, 1, 0);
    checkOutput("ffff+ffff+1-busycycles", busyCnt, 4);
    @(negedge clk);
    checkOutput("b2b-busy", int'(obsBusy[2]), 1);
    checkOutput("b2b-done", int'(obsDone[2]), 0);
    stStart[2] = 1'b0;
    waitDone(2, "1234+4321", busyCnt);
    checkResult(2, "1234+4321", 'h5555, 0, 0);
    checkOutput("1234+4321-busycycles", busyCnt, 4);

    $display("[TB] reset during RUN");
    applyStimulus(0, 16'h0012, 16'h0034, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkResult(0, "midreset-cfg0", 0, 0, 0);
    checkOutput("midreset-busy", int'(obsBusy[0]), 0);
    checkOutput("midreset-cfg2-sum", int'(obsSum[2]), 0);
    @(negedge clk);
    rstN = 1'b1;
    doneCnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (obsDone[0] === 1'b1) doneCnt++;
    end
    checkOutput("midreset-nodone", doneCnt, 0);
    applyStimulus(0, 16'h0012, 16'h0034, 1'b0);
    waitDone(0, "postreset", busyCnt);
    checkResult(0, "postreset", 'h46, 0, 0);

    $display("[TB] random operands on all configurations");
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 1000; k++) begin
        applyStimulus(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        waitDone(i, $sformatf("rand-cfg%0d", i), busyCnt);
        checkOutput($sformatf("rand-cfg%0d-latency", i), busyCnt, cfgN(i));
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
